// File: rtl/accel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | accel_pkg : shared FSM encoding and defaults for accel blocks  |
// | rev 1.0                                                        |
// +----------------------------------------------------------------+
package accel_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  // Wait counter is sized for the largest legal TIMEOUT (255)
  localparam int CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_pick : combinational circular search, first req at/after ptr|
// | rev 1.0                                                        |
// +----------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  localparam int SW = IDX_W + 1;

  logic [SW-1:0] w_sum;

  // Scan from the farthest offset down so the nearest requester wins
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    w_sum = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_sum = {1'b0, ptr_i} + SW'(i);
      if (w_sum >= SW'(NUM_CH)) begin
        w_sum = w_sum - SW'(NUM_CH);
      end
      if (req_i[w_sum[IDX_W-1:0]]) begin
        idx_o = w_sum[IDX_W-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/occ_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | occ_rom_arbiter : round-robin sharing of one Occ ROM by lanes  |
// | rev 1.0                                                        |
// +----------------------------------------------------------------+
module occ_rom_arbiter
  import accel_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  output logic [NUM_CH-1:0]        resp_valid_o,
  output logic [DATA_W-1:0]        resp_data_o,
  output logic                     resp_err_o,
  output logic                     busy_o,
  output logic                     ce_rom_Occ_o,
  output logic [ADDR_W-1:0]        addr_rom_Occ_o,
  input  logic [DATA_W-1:0]        data_Occ_i,
  input  logic                     data_Occ_valid_i
);

  localparam int IDX_W = $clog2(NUM_CH);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  id_q, id_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic [CNT_W-1:0]  w_cnt_inc;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req_i  (req_i),
    .ptr_i  (rr_q),
    .idx_o  (w_pick_idx),
    .any_o  (w_pick_any)
  );

  // Saturating increment; the counter never wraps past TIMEOUT
  assign w_cnt_inc = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_any) begin
          id_d    = w_pick_idx;
          addr_d  = addr_i[w_pick_idx*ADDR_W +: ADDR_W];
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (data_Occ_valid_i) begin
          data_d  = data_Occ_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
          data_d  = '0;
          err_d   = 1'b1;
          cnt_d   = w_cnt_inc;
          state_d = ST_RESP;
        end else begin
          cnt_d   = w_cnt_inc;
        end
      end
      ST_RESP: begin
        rr_d    = (id_q == IDX_W'(NUM_CH - 1)) ? '0 : id_q + IDX_W'(1);
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_resp
    assign resp_valid_o[k] = (state_q == ST_RESP) && (id_q == IDX_W'(k));
  end

  assign resp_data_o    = (state_q == ST_RESP) ? data_q : '0;
  assign resp_err_o     = (state_q == ST_RESP) && err_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign ce_rom_Occ_o   = (state_q == ST_ISSUE);
  assign addr_rom_Occ_o = (state_q == ST_ISSUE) ? addr_q : '0;

endmodule
`default_nettype wire
